// File: rtl/cpu_ctrl_gen2.sv
// Front-panel CPU controller: instruction latch, decode/execute/writeback sequencing and an
// HD44780 LCD driver. Define DISPLAY_HEX_EN to render DISPLAY values as ASCII hex.
module cpu_ctrl_gen2 #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned LCD_DELAY    = 50000,
  parameter int unsigned LCD_E_CYCLES = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_power,
  input  logic              key_send,
  input  logic [17:0]       instr,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              led_off,
  output logic              led_ready,
  output logic              busy,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [3:0]        rf_raddr_a,
  output logic [3:0]        rf_raddr_b,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [7:0]        lcd_data,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_e
);

  localparam int unsigned NIB     = DATA_W / 4;
  localparam int unsigned CNT_MAX = (LCD_DELAY > LCD_E_CYCLES) ? LCD_DELAY : LCD_E_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = $clog2(NIB + 2);
`ifdef DISPLAY_HEX_EN
  localparam int unsigned DISP_LAST = NIB;
`else
  localparam int unsigned DISP_LAST = 1;
`endif

  localparam logic [2:0] OpLoad    = 3'b000;
  localparam logic [2:0] OpAdd     = 3'b001;
  localparam logic [2:0] OpAddi    = 3'b010;
  localparam logic [2:0] OpSub     = 3'b011;
  localparam logic [2:0] OpSubi    = 3'b100;
  localparam logic [2:0] OpMuli    = 3'b101;
  localparam logic [2:0] OpClear   = 3'b110;
  localparam logic [2:0] OpDisplay = 3'b111;

  typedef enum logic [2:0] {
    StOff, StInit, StIdle, StDecode, StExecute, StWriteback, StLcdXfer, StLcdWait
  } state_e;

  state_e            state_q, state_d;
  logic              key_power_q, key_send_q;
  logic [17:0]       instr_q, instr_d;
  logic [DATA_W-1:0] alu_res_q, alu_res_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              lcd_init_q, lcd_init_d;
  logic [7:0]        lcd_data_q;
  logic              lcd_rs_q;
  logic              load_byte;
  logic [IDX_W-1:0]  sel_idx, last_idx;
  logic              sel_init;
  logic [7:0]        sel_data;
  logic              sel_rs;

  logic              power_edge, send_edge;
  logic [2:0]        op;
  logic              is_rtype;
  logic [3:0]        rd, rs1, rs2;
  logic [DATA_W-1:0] imm_sext;

  assign power_edge = key_power_q & ~key_power;
  assign send_edge  = key_send_q & ~key_send;

  assign op       = instr_q[17:15];
  assign is_rtype = (op == OpAdd) || (op == OpSub);
  assign rd       = is_rtype ? instr_q[11:8] : (op == OpClear) ? instr_q[3:0] : instr_q[14:11];
  assign rs1      = is_rtype ? instr_q[7:4] : (op == OpDisplay) ? instr_q[3:0] :
                    (op == OpClear) ? 4'h0 : instr_q[10:7];
  assign rs2      = is_rtype ? instr_q[3:0] : 4'h0;
  assign imm_sext = {{(DATA_W-7){instr_q[6]}}, instr_q[6:0]};

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Byte to launch next: index 0 of a DISPLAY is the clear command, chars follow.
  assign sel_idx  = (state_q == StLcdWait) ? idx_q + IDX_W'(1) : '0;
  assign sel_init = (state_q == StDecode) ? 1'b0 : lcd_init_q;
  assign last_idx = lcd_init_q ? IDX_W'(3) : IDX_W'(DISP_LAST);

  always_comb begin
    sel_data = 8'h00;
    sel_rs   = 1'b0;
    if (sel_init) begin
      case (sel_idx)
        IDX_W'(0): sel_data = 8'h38;
        IDX_W'(1): sel_data = 8'h0C;
        IDX_W'(2): sel_data = 8'h01;
        default:   sel_data = 8'h06;
      endcase
    end else if (sel_idx == '0) begin
      sel_data = 8'h01;
    end else begin
      sel_rs = 1'b1;
`ifdef DISPLAY_HEX_EN
      for (int k = 0; k < int'(NIB); k++) begin
        if (sel_idx == IDX_W'(int'(NIB) - k)) sel_data = hex_char(rf_rdata_a[4*k +: 4]);
      end
`else
      sel_data = rf_rdata_a[7:0];
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    lcd_init_d = lcd_init_q;
    instr_d    = instr_q;
    alu_res_d  = alu_res_q;
    load_byte  = 1'b0;
    unique case (state_q)
      StOff: begin
        if (power_edge) begin
          state_d    = StInit;
          lcd_init_d = 1'b1;
          idx_d      = '0;
        end
      end
      StInit: begin
        load_byte = 1'b1;
        cnt_d     = '0;
        state_d   = StLcdXfer;
      end
      StIdle: begin
        if (power_edge) begin
          state_d = StOff;
        end else if (send_edge) begin
          instr_d = instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        unique case (op)
          OpLoad, OpClear: state_d = StWriteback;
          OpDisplay: begin
            lcd_init_d = 1'b0;
            idx_d      = '0;
            load_byte  = 1'b1;
            cnt_d      = '0;
            state_d    = StLcdXfer;
          end
          default: state_d = StExecute;
        endcase
      end
      StExecute: begin
        // Operands are only driven here, so capture the ALU result for writeback.
        alu_res_d = alu_result;
        state_d   = StWriteback;
      end
      StWriteback: state_d = StIdle;
      StLcdXfer: begin
        if (cnt_q == CNT_W'(LCD_E_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StLcdWait;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StLcdWait: begin
        if (cnt_q == CNT_W'(LCD_DELAY - 1)) begin
          cnt_d = '0;
          if (idx_q == last_idx) begin
            state_d = StIdle;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            load_byte = 1'b1;
            state_d   = StLcdXfer;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StOff;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StOff;
      key_power_q <= 1'b1;
      key_send_q  <= 1'b1;
      instr_q     <= '0;
      alu_res_q   <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      lcd_init_q  <= 1'b0;
      lcd_data_q  <= 8'h00;
      lcd_rs_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_power_q <= key_power;
      key_send_q  <= key_send;
      instr_q     <= instr_d;
      alu_res_q   <= alu_res_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      lcd_init_q  <= lcd_init_d;
      if (load_byte) begin
        lcd_data_q <= sel_data;
        lcd_rs_q   <= sel_rs;
      end
    end
  end

  always_comb begin
    rf_we      = 1'b0;
    rf_waddr   = 4'h0;
    rf_raddr_a = 4'h0;
    rf_raddr_b = 4'h0;
    rf_wdata   = '0;
    alu_op     = 3'b000;
    alu_a      = '0;
    alu_b      = '0;
    unique case (state_q)
      StDecode: begin
        rf_raddr_a = rs1;
        rf_raddr_b = rs2;
      end
      StExecute: begin
        rf_raddr_a = rs1;
        rf_raddr_b = rs2;
        alu_a      = rf_rdata_a;
        alu_b      = is_rtype ? rf_rdata_b : imm_sext;
        unique case (op)
          OpSub, OpSubi: alu_op = 3'b001;
          OpMuli:        alu_op = 3'b010;
          default:       alu_op = 3'b000;
        endcase
      end
      StWriteback: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        unique case (op)
          OpLoad:  rf_wdata = imm_sext;
          OpClear: rf_wdata = '0;
          default: rf_wdata = alu_res_q;
        endcase
      end
      StLcdXfer, StLcdWait: begin
        if (!lcd_init_q) rf_raddr_a = rs1;
      end
      default: ;
    endcase
  end

  assign led_off   = (state_q == StOff);
  assign led_ready = (state_q == StIdle);
  assign busy      = (state_q != StOff) && (state_q != StIdle);
  assign lcd_e     = (state_q == StLcdXfer);
  assign lcd_rw    = 1'b0;
  assign lcd_data  = lcd_data_q;
  assign lcd_rs    = lcd_rs_q;

endmodule

// File: tb/tb_cpu_ctrl_gen2.sv
// Directed bench for cpu_ctrl_gen2: power-up LCD init, LOAD/ALU/CLEAR sequencing, DISPLAY,
// key priority and asynchronous reset during an LCD transfer.
module tb_cpu_ctrl_gen2;

  localparam int DW  = 16;
  localparam int DLY = 4;
  localparam int EC  = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          key_power, key_send;
  logic [17:0]   instr;
  logic [DW-1:0] rf_rdata_a, rf_rdata_b, alu_result;
  logic          led_off, led_ready, busy, rf_we;
  logic [3:0]    rf_waddr, rf_raddr_a, rf_raddr_b;
  logic [DW-1:0] rf_wdata, alu_a, alu_b;
  logic [2:0]    alu_op;
  logic [7:0]    lcd_data;
  logic          lcd_rs, lcd_rw, lcd_e;

  int vectors = 0;
  int miscompares = 0;

  cpu_ctrl_gen2 #(.DATA_W(DW), .LCD_DELAY(DLY), .LCD_E_CYCLES(EC)) dut (
    .clk(clk), .reset(reset), .key_power(key_power), .key_send(key_send), .instr(instr),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .alu_result(alu_result),
    .led_off(led_off), .led_ready(led_ready), .busy(busy), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_wdata(rf_wdata), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Wait for the next lcd_e pulse and check its byte, rs, width, stability and preceding gap.
  task automatic lcd_expect(input string tag, input logic [7:0] d, input logic r,
                            input bit chk_gap);
    int gap = 0;
    int hi = 0;
    bit stable = 1'b1;
    while (lcd_e !== 1'b1 && gap < 200) begin
      step();
      gap++;
    end
    chk({tag, "_data"}, lcd_data, d);
    chk({tag, "_rs"}, lcd_rs, r);
    while (lcd_e === 1'b1 && hi < 100) begin
      if (lcd_data !== d || lcd_rs !== r) stable = 1'b0;
      hi++;
      step();
    end
    chk({tag, "_e_cycles"}, hi, EC);
    chk({tag, "_stable"}, stable, 1);
    if (chk_gap) chk({tag, "_gap"}, gap, DLY);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (led_ready !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    chk(tag, led_ready, 1);
  endtask

  task automatic power_on();
    key_power = 1'b0;
    step();
    key_power = 1'b1;
    chk("init_busy", busy, 1);
    chk("init_led_off", led_off, 0);
    lcd_expect("init0", 8'h38, 1'b0, 1'b0);
    lcd_expect("init1", 8'h0C, 1'b0, 1'b1);
    lcd_expect("init2", 8'h01, 1'b0, 1'b1);
    lcd_expect("init3", 8'h06, 1'b0, 1'b1);
    wait_ready("init_ready");
    chk("init_idle_busy", busy, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    key_power = 1'b1;
    key_send = 1'b1;
    instr = '0;
    rf_rdata_a = '0;
    rf_rdata_b = '0;
    alu_result = '0;
    step();
    step();
    chk("rst_led_off", led_off, 1);
    chk("rst_led_ready", led_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_lcd_e", lcd_e, 0);
    chk("rst_lcd_data", lcd_data, 0);
    chk("rst_lcd_rs", lcd_rs, 0);
    chk("rst_lcd_rw", lcd_rw, 0);
    chk("rst_alu_op", alu_op, 0);
    reset = 1'b0;
    step();
    chk("rel_led_off", led_off, 1);
    chk("rel_rf_we", rf_we, 0);

    power_on();

    // LOAD r3,-5: op 000, rd [14:11]=3, imm 0x7B
    instr = 18'h0187B;
    key_send = 1'b0;
    step();
    key_send = 1'b1;
    chk("load_c1_we", rf_we, 0);
    chk("load_c1_busy", busy, 1);
    step();
    chk("load_c2_we", rf_we, 1);
    chk("load_waddr", rf_waddr, 3);
    chk("load_wdata", rf_wdata, 16'hFFFB);
    step();
    chk("load_c3_we", rf_we, 0);
    chk("load_ready", led_ready, 1);

    // ADD r1,r2,r3
    instr = 18'h08123;
    rf_rdata_a = 16'h0010;
    rf_rdata_b = 16'h0022;
    alu_result = 16'h0032;
    key_send = 1'b0;
    step();
    key_send = 1'b1;
    chk("add_dec_raddr_a", rf_raddr_a, 2);
    chk("add_dec_raddr_b", rf_raddr_b, 3);
    chk("add_dec_alu_a", alu_a, 0);
    step();
    chk("add_ex_op", alu_op, 3'b000);
    chk("add_ex_a", alu_a, 16'h0010);
    chk("add_ex_b", alu_b, 16'h0022);
    chk("add_ex_raddr_a", rf_raddr_a, 2);
    chk("add_ex_we", rf_we, 0);
    step();
    chk("add_wb_we", rf_we, 1);
    chk("add_wb_waddr", rf_waddr, 1);
    chk("add_wb_wdata", rf_wdata, 16'h0032);
    chk("add_wb_alu_a", alu_a, 0);
    step();
    chk("add_after_we", rf_we, 0);

    // SUBI r4,r1,-1 with switches scrambled during EXECUTE
    instr = 18'h220FF;
    rf_rdata_a = 16'h0005;
    alu_result = 16'h0006;
    key_send = 1'b0;
    step();
    key_send = 1'b1;
    chk("subi_dec_raddr_a", rf_raddr_a, 1);
    chk("subi_dec_raddr_b", rf_raddr_b, 0);
    step();
    chk("subi_ex_op", alu_op, 3'b001);
    chk("subi_ex_a", alu_a, 16'h0005);
    chk("subi_ex_b", alu_b, 16'hFFFF);
    instr = 18'h3FFFF;
    step();
    chk("subi_wb_we", rf_we, 1);
    chk("subi_wb_waddr", rf_waddr, 4);
    chk("subi_wb_wdata", rf_wdata, 16'h0006);
    step();

    // MULI r7,r2,3
    instr = 18'h2B903;
    rf_rdata_a = 16'h0009;
    alu_result = 16'h001B;
    key_send = 1'b0;
    step();
    key_send = 1'b1;
    step();
    chk("muli_ex_op", alu_op, 3'b010);
    chk("muli_ex_b", alu_b, 16'h0003);
    step();
    chk("muli_wb_waddr", rf_waddr, 7);
    chk("muli_wb_wdata", rf_wdata, 16'h001B);
    step();

    // CLEAR r9
    instr = 18'h30009;
    alu_result = 16'hBEEF;
    key_send = 1'b0;
    step();
    key_send = 1'b1;
    chk("clr_c1_we", rf_we, 0);
    step();
    chk("clr_wb_we", rf_we, 1);
    chk("clr_wb_waddr", rf_waddr, 9);
    chk("clr_wb_wdata", rf_wdata, 0);
    step();

    // Both keys in IDLE: power wins, nothing written
    instr = 18'h0187B;
    key_power = 1'b0;
    key_send = 1'b0;
    step();
    key_power = 1'b1;
    key_send = 1'b1;
    chk("both_led_off", led_off, 1);
    chk("both_busy", busy, 0);
    step();
    chk("both_we", rf_we, 0);
    power_on();

    // DISPLAY r5
    instr = 18'h38005;
    rf_rdata_a = 16'h1A2F;
    key_send = 1'b0;
    step();
    key_send = 1'b1;
    chk("disp_dec_raddr_a", rf_raddr_a, 5);
    lcd_expect("disp_clr", 8'h01, 1'b0, 1'b0);
    chk("disp_raddr_a_held", rf_raddr_a, 5);
`ifdef DISPLAY_HEX_EN
    lcd_expect("disp_h0", 8'h31, 1'b1, 1'b1);
    lcd_expect("disp_h1", 8'h41, 1'b1, 1'b1);
    lcd_expect("disp_h2", 8'h32, 1'b1, 1'b1);
    lcd_expect("disp_h3", 8'h46, 1'b1, 1'b1);
`else
    lcd_expect("disp_raw", 8'h2F, 1'b1, 1'b1);
`endif
    wait_ready("disp_ready");

    // Keys ignored mid-transfer, then asynchronous reset during LCD_XFER
    key_send = 1'b0;
    step();
    key_send = 1'b1;
    n = 0;
    while (lcd_e !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("rst_xfer_e_seen", lcd_e, 1);
    step();
    key_power = 1'b0;
    step();
    key_power = 1'b1;
    chk("busy_key_ignored", busy, 1);
    chk("busy_key_led_off", led_off, 0);
    chk("busy_key_e", lcd_e, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_xfer_e", lcd_e, 0);
    chk("rst_xfer_led_off", led_off, 1);
    chk("rst_xfer_busy", busy, 0);
    chk("rst_xfer_data", lcd_data, 0);
    step();
    reset = 1'b0;
    step();
    chk("rst_rel_we", rf_we, 0);
    chk("rst_rel_e", lcd_e, 0);
    chk("rst_rel_off", led_off, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
